mul_pipeline: RTL and testbench

- Multi-cycle integer multiply unit for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Sits directly downstream of the ID/EX register and runs in parallel with the single-cycle ALU.
- Consumes the ID/EX operand, destination and ROB fields, then carries them through LATENCY register stages.
- Presents a completed result to the writeback/ROB path, plus a RAW-hazard flag for decode.

---
 rtl/mul_pipeline_pkg.sv | 31 +++
 rtl/mul_pipeline_if.sv | 51 +++++
 rtl/mul_pipe_stage.sv | 49 ++++
 rtl/mul_pipeline.sv | 130 +++++++++++++
 tb/tb_mul_pipeline.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_pipeline_pkg                                             |
// | Description : Shared constants and stage payload type for the RV32M        |
// |               multiply pipeline (opcode/funct fields, exception codes).    |
// | Ports       : none (package)                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mul_pipeline_pkg;

   localparam logic [6:0] OPCODE_OP   = 7'b0110011;
   localparam logic [6:0] MUL_FUNCT7  = 7'b0000001;

   localparam logic [2:0] F3_MUL      = 3'b000;
   localparam logic [2:0] F3_MULH     = 3'b001;
   localparam logic [2:0] F3_MULHSU   = 3'b010;
   localparam logic [2:0] F3_MULHU    = 3'b011;

   localparam logic [2:0] EXC_NONE    = 3'b000;
   localparam logic [2:0] EXC_ILLEGAL = 3'b010;

   // Bookkeeping that travels with every op, independent of the datapath width.
   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [3:0]  idx;
      logic [2:0]  exc;
   } mul_stage_t;

endpackage
`default_nettype wire

// File: rtl/mul_pipeline_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_pipeline_if                                              |
// | Description : Issue, control, hazard and result signals of the multiply    |
// |               pipeline. master = ID/EX + decode side, slave = the unit.    |
// | Ports       : in_* issue/control/decode fields, out_* result and status    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface mul_pipeline_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic [2:0]      in_funct3;
   logic [XLEN-1:0] in_data_rs1;
   logic [XLEN-1:0] in_data_rs2;
   logic [4:0]      in_rd;
   logic [31:0]     in_PC;
   logic [3:0]      in_complete_idx;
   logic [2:0]      in_exception_vector;
   logic            in_stall;
   logic            in_flush;
   logic [4:0]      in_dec_rs1;
   logic [4:0]      in_dec_rs2;

   logic            out_valid;
   logic [XLEN-1:0] out_result;
   logic [4:0]      out_rd;
   logic [31:0]     out_PC;
   logic [3:0]      out_complete_idx;
   logic [2:0]      out_exception_vector;
   logic            out_write_enable;
   logic            out_raw_hazard;
   logic            out_busy;

   modport master (
      output in_valid, in_funct3, in_data_rs1, in_data_rs2, in_rd, in_PC,
             in_complete_idx, in_exception_vector, in_stall, in_flush,
             in_dec_rs1, in_dec_rs2,
      input  out_valid, out_result, out_rd, out_PC, out_complete_idx,
             out_exception_vector, out_write_enable, out_raw_hazard, out_busy
   );

   modport slave (
      input  in_valid, in_funct3, in_data_rs1, in_data_rs2, in_rd, in_PC,
             in_complete_idx, in_exception_vector, in_stall, in_flush,
             in_dec_rs1, in_dec_rs2,
      output out_valid, out_result, out_rd, out_PC, out_complete_idx,
             out_exception_vector, out_write_enable, out_raw_hazard, out_busy
   );
endinterface
`default_nettype wire

// File: rtl/mul_pipe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_pipe_stage                                               |
// | Description : One register stage of the multiply pipeline. Priority:       |
// |               reset > flush (drop valid) > stall (hold) > capture.         |
// | Ports       : clk, reset, flush_i, stall_i, valid_i/meta_i/data_i in,      |
// |               valid_o/meta_o/data_o registered out                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_pipe_stage
   import mul_pipeline_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush_i,
   input  logic          stall_i,
   input  logic          valid_i,
   input  mul_stage_t    meta_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output mul_stage_t    meta_o,
   output logic [DW-1:0] data_o
);
   logic          valid_q;
   mul_stage_t    meta_q;
   logic [DW-1:0] data_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         meta_q  <= '0;
         data_q  <= '0;
      end else if (flush_i) begin
         // Payload is left stale; without valid it is never acted upon.
         valid_q <= 1'b0;
      end else if (!stall_i) begin
         valid_q <= valid_i;
         meta_q  <= meta_i;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign meta_o  = meta_q;
   assign data_o  = data_q;
endmodule
`default_nettype wire

// File: rtl/mul_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_pipeline                                                 |
// | Description : LATENCY-stage RV32M multiply unit (MUL/MULH/MULHSU/MULHU).   |
// |               s[1] holds extended operands, the product is formed between  |
// |               s[1] and s[2], later stages only carry the result.           |
// | Ports       : clk, reset, bus (mul_pipeline_if.slave: issue, stall/flush,  |
// |               decode rs1/rs2 in; result, write enable, hazard, busy out)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mul_pipeline
   import mul_pipeline_pkg::*;
#(
   parameter int LATENCY = 5,
   parameter int XLEN    = 32
) (
   input  logic         clk,
   input  logic         reset,
   mul_pipeline_if.slave bus
);
   localparam int OPW = XLEN + 1;        // operand width after sign/zero extension
   localparam int S1W = 3 + 2 * OPW;     // funct3 + both extended operands

   logic                   rs1_signed;
   logic                   rs2_signed;
   logic [2:0]             exc_d;
   logic [S1W-1:0]         s1_data_d;
   logic [S1W-1:0]         s1_data_q;
   logic [LATENCY:0]       stg_valid;
   mul_stage_t             stg_meta [0:LATENCY];
   logic [XLEN-1:0]        res_data [1:LATENCY];
   logic [2:0]             s1_funct3;
   logic [OPW-1:0]         s1_op_a;
   logic [OPW-1:0]         s1_op_b;
   logic signed [2*XLEN-1:0] mul_a;
   logic signed [2*XLEN-1:0] mul_b;
   logic signed [2*XLEN-1:0] prod;
   logic [XLEN-1:0]        result_d;
   logic                   hazard;

   // Only MULH treats rs2 as signed; MULH and MULHSU treat rs1 as signed.
   assign rs1_signed = (bus.in_funct3 == F3_MULH) || (bus.in_funct3 == F3_MULHSU);
   assign rs2_signed = (bus.in_funct3 == F3_MULH);

   // An upstream exception wins over the illegal-funct3 (DIV/REM) code.
   assign exc_d = (bus.in_exception_vector != EXC_NONE) ? bus.in_exception_vector :
                  (bus.in_funct3[2] ? EXC_ILLEGAL : EXC_NONE);

   assign stg_valid[0] = bus.in_valid;
   assign stg_meta[0]  = '{rd: bus.in_rd, pc: bus.in_PC,
                           idx: bus.in_complete_idx, exc: exc_d};
   assign s1_data_d    = {bus.in_funct3,
                          rs1_signed & bus.in_data_rs1[XLEN-1], bus.in_data_rs1,
                          rs2_signed & bus.in_data_rs2[XLEN-1], bus.in_data_rs2};

   assign s1_funct3 = s1_data_q[S1W-1 -: 3];
   assign s1_op_a   = s1_data_q[2*OPW-1 -: OPW];
   assign s1_op_b   = s1_data_q[OPW-1:0];

   // XLEN+1-bit signed operands; the low 2*XLEN bits of their product are
   // exact for every variant, so the multiply is done at 2*XLEN width.
   assign mul_a = {{(XLEN-1){s1_op_a[OPW-1]}}, s1_op_a};
   assign mul_b = {{(XLEN-1){s1_op_b[OPW-1]}}, s1_op_b};
   assign prod  = mul_a * mul_b;

   always_comb begin
      result_d = '0;
      if (stg_meta[1].exc == EXC_NONE) begin
         case (s1_funct3)
            F3_MUL:                       result_d = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_d = prod[2*XLEN-1:XLEN];
            default:                      result_d = '0;
         endcase
      end
   end

   assign res_data[1] = result_d;

   for (genvar i = 1; i <= LATENCY; i++) begin : g_stage
      if (i == 1) begin : g_operands
         mul_pipe_stage #(.DW(S1W)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush_i (bus.in_flush),
            .stall_i (bus.in_stall),
            .valid_i (stg_valid[0]),
            .meta_i  (stg_meta[0]),
            .data_i  (s1_data_d),
            .valid_o (stg_valid[1]),
            .meta_o  (stg_meta[1]),
            .data_o  (s1_data_q)
         );
      end else begin : g_result
         mul_pipe_stage #(.DW(XLEN)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .flush_i (bus.in_flush),
            .stall_i (bus.in_stall),
            .valid_i (stg_valid[i-1]),
            .meta_i  (stg_meta[i-1]),
            .data_i  (res_data[i-1]),
            .valid_o (stg_valid[i]),
            .meta_o  (stg_meta[i]),
            .data_o  (res_data[i])
         );
      end
   end

   // No forwarding out of this unit: any in-flight writer of a decode source stalls decode.
   always_comb begin
      hazard = 1'b0;
      for (int i = 1; i <= LATENCY; i++) begin
         if (stg_valid[i] && (stg_meta[i].rd != 5'd0) &&
             ((stg_meta[i].rd == bus.in_dec_rs1) || (stg_meta[i].rd == bus.in_dec_rs2)))
            hazard = 1'b1;
      end
   end

   assign bus.out_valid            = stg_valid[LATENCY];
   assign bus.out_result           = res_data[LATENCY];
   assign bus.out_rd               = stg_meta[LATENCY].rd;
   assign bus.out_PC               = stg_meta[LATENCY].pc;
   assign bus.out_complete_idx     = stg_meta[LATENCY].idx;
   assign bus.out_exception_vector = stg_meta[LATENCY].exc;
   assign bus.out_write_enable     = stg_valid[LATENCY] && (stg_meta[LATENCY].rd != 5'd0) &&
                                     (stg_meta[LATENCY].exc == EXC_NONE);
   assign bus.out_raw_hazard       = hazard;
   assign bus.out_busy             = |stg_valid[LATENCY:1];
endmodule
`default_nettype wire

// File: tb/tb_mul_pipeline.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_pipeline                                              |
// | Description : Self-checking bench for mul_pipeline: directed scenarios     |
// |               plus a randomized run against a queue-based reference model. |
// | Ports       : none                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mul_pipeline;
   import mul_pipeline_pkg::*;

   localparam int LAT = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mul_pipeline_if #(.XLEN(32)) bus ();

   mul_pipeline #(.LATENCY(LAT), .XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference model: every op in flight with the number of advances it has seen.
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [3:0]  idx;
      logic [2:0]  exc;
      logic [31:0] res;
      int          age;
   } op_t;
   op_t mq[$];

   function automatic void ref_op(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [2:0] exc_in,
                                  output logic [2:0] exc, output logic [31:0] res);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      p   = '0;
      exc = (exc_in != 3'd0) ? exc_in : (f3[2] ? 3'b010 : 3'b000);
      res = '0;
      if (exc == 3'd0) begin
         case (f3)
            3'd0:    begin p = {32'd0, a} * {32'd0, b}; res = p[31:0];  end
            3'd1:    begin p = sa * sb;                 res = p[63:32]; end
            3'd2:    begin p = sa * longint'({32'd0, b}); res = p[63:32]; end
            default: begin p = {32'd0, a} * {32'd0, b}; res = p[63:32]; end
         endcase
      end
   endfunction

   task automatic model_step();
      op_t o;
      if (reset || bus.in_flush) begin
         mq.delete();
      end else if (!bus.in_stall) begin
         foreach (mq[k]) mq[k].age++;
         while (mq.size() > 0 && mq[0].age > LAT) void'(mq.pop_front());
         if (bus.in_valid) begin
            ref_op(bus.in_funct3, bus.in_data_rs1, bus.in_data_rs2,
                   bus.in_exception_vector, o.exc, o.res);
            o.rd  = bus.in_rd;
            o.pc  = bus.in_PC;
            o.idx = bus.in_complete_idx;
            o.age = 1;
            mq.push_back(o);
         end
      end
   endtask

   function automatic logic model_valid();
      return (mq.size() > 0) && (mq[0].age == LAT);
   endfunction

   function automatic logic model_hazard();
      foreach (mq[k])
         if (mq[k].rd != 5'd0 && (mq[k].rd == bus.in_dec_rs1 || mq[k].rd == bus.in_dec_rs2))
            return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] pc,
                         input logic [3:0] idx, input logic [2:0] exc);
      bus.in_valid            = 1'b1;
      bus.in_funct3           = f3;
      bus.in_data_rs1         = a;
      bus.in_data_rs2         = b;
      bus.in_rd               = rd;
      bus.in_PC               = pc;
      bus.in_complete_idx     = idx;
      bus.in_exception_vector = exc;
   endtask

   task automatic idle();
      bus.in_valid            = 1'b0;
      bus.in_funct3           = 3'd0;
      bus.in_data_rs1         = 32'd0;
      bus.in_data_rs2         = 32'd0;
      bus.in_rd               = 5'd0;
      bus.in_PC               = 32'd0;
      bus.in_complete_idx     = 4'd0;
      bus.in_exception_vector = 3'd0;
   endtask

   task automatic drain();
      idle();
      bus.in_stall = 1'b0;
      bus.in_flush = 1'b0;
      repeat (LAT + 2) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      bus.in_stall = 1'b0; bus.in_flush = 1'b0;
      bus.in_dec_rs1 = 5'd0; bus.in_dec_rs2 = 5'd0;
      repeat (3) tick();
      checks++;
      if ({bus.out_valid, bus.out_write_enable, bus.out_raw_hazard, bus.out_busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: got v=%b we=%b hz=%b busy=%b, expected all 0",
                  bus.out_valid, bus.out_write_enable, bus.out_raw_hazard, bus.out_busy);
      end
      checks++;
      if ({bus.out_result, bus.out_rd, bus.out_PC, bus.out_complete_idx, bus.out_exception_vector} !== '0) begin
         errors++;
         $display("FAIL reset_fields: got res=%h rd=%0d pc=%h idx=%0d exc=%0d, expected all 0",
                  bus.out_result, bus.out_rd, bus.out_PC, bus.out_complete_idx, bus.out_exception_vector);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_mul_basic();
      set_op(F3_MUL, 32'd7, 32'd6, 5'd5, 32'h0000_1000, 4'd3, 3'd0);
      tick();
      idle();
      for (int c = 1; c <= 6; c++) begin
         checks++;
         if (bus.out_valid !== (c == LAT)) begin
            errors++;
            $display("FAIL mul_valid cycle %0d: got %b expected %b", c, bus.out_valid, c == LAT);
         end
         if (c == LAT) begin
            checks++;
            if (bus.out_result !== 32'd42 || bus.out_rd !== 5'd5 || bus.out_complete_idx !== 4'd3 ||
                bus.out_PC !== 32'h0000_1000 || bus.out_write_enable !== 1'b1) begin
               errors++;
               $display("FAIL mul_fields: got res=%0d rd=%0d idx=%0d pc=%h we=%b expected 42 5 3 00001000 1",
                        bus.out_result, bus.out_rd, bus.out_complete_idx, bus.out_PC, bus.out_write_enable);
            end
         end
         tick();
      end
   endtask

   task automatic test_signedness();
      logic [2:0]  f3s [4];
      logic [31:0] as  [4];
      logic [31:0] bs  [4];
      logic [31:0] exp [4];
      f3s = '{F3_MULH, F3_MULHU, F3_MULHSU, F3_MUL};
      as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      bs  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0002};
      exp = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
      for (int c = 0; c < 10; c++) begin
         if (c < 4) set_op(f3s[c], as[c], bs[c], 5'(c + 8), 32'h200 + 32'(c * 4), 4'(c), 3'd0);
         else idle();
         tick();
         if (c + 1 >= LAT && c + 1 < LAT + 4) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== exp[c + 1 - LAT]) begin
               errors++;
               $display("FAIL sign_op%0d: got v=%b res=%h expected v=1 res=%h",
                        c + 1 - LAT, bus.out_valid, bus.out_result, exp[c + 1 - LAT]);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] a [4];
      logic [31:0] b [4];
      logic [31:0] r [4];
      logic [2:0]  e;
      logic [31:0] held;
      int          k;
      for (int i = 0; i < 4; i++) begin
         a[i] = $urandom;
         b[i] = $urandom;
         ref_op(3'(i), a[i], b[i], 3'd0, e, r[i]);
      end
      k = 0;
      for (int c = 0; c < 12; c++) begin
         bus.in_stall = (c == 2 || c == 3);
         if (k < 4) set_op(3'(k), a[k], b[k], 5'(k + 1), 32'h300 + 32'(k * 4), 4'(k), 3'd0);
         else idle();
         tick();
         if (!(c == 2 || c == 3) && k < 4) k++;
         checks++;
         if (bus.out_valid !== (c + 1 >= 7 && c + 1 <= 10)) begin
            errors++;
            $display("FAIL stall_valid cycle %0d: got %b expected %b", c + 1, bus.out_valid,
                     (c + 1 >= 7 && c + 1 <= 10));
         end else if (bus.out_valid && (bus.out_result !== r[c + 1 - 7] || bus.out_rd !== 5'(c + 1 - 6))) begin
            checks++;
            errors++;
            $display("FAIL stall_order cycle %0d: got res=%h rd=%0d expected res=%h rd=%0d",
                     c + 1, bus.out_result, bus.out_rd, r[c + 1 - 7], c + 1 - 6);
         end
      end
      bus.in_stall = 1'b0;
      drain();
      // Stall while a result sits at the output: it must hold.
      set_op(F3_MUL, 32'd1234, 32'd5678, 5'd9, 32'h400, 4'd9, 3'd0);
      tick();
      idle();
      repeat (LAT - 1) tick();
      held = bus.out_result;
      bus.in_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd7006652 || bus.out_result !== held) begin
            errors++;
            $display("FAIL stall_hold %0d: got v=%b res=%0d expected v=1 res=7006652", c,
                     bus.out_valid, bus.out_result);
         end
      end
      bus.in_stall = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: got v=%b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_flush();
      for (int c = 0; c < 12; c++) begin
         bus.in_flush = (c == 2);
         if (c < 3) set_op(F3_MUL, 32'd3, 32'd3, 5'd7, 32'h500, 4'(c), 3'd0);
         else idle();
         if (c == 2) begin
            checks++;
            if (bus.out_busy !== 1'b1) begin
               errors++;
               $display("FAIL flush_busy_before: got %b expected 1", bus.out_busy);
            end
         end
         tick();
         if (c >= 2) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.out_busy !== 1'b0) begin
               errors++;
               $display("FAIL flush cycle %0d: got v=%b busy=%b expected 0 0", c + 1,
                        bus.out_valid, bus.out_busy);
            end
         end
      end
      bus.in_flush = 1'b0;
      set_op(F3_MULHU, 32'hFFFF_0000, 32'h1234_5678, 5'd4, 32'h600, 4'd1, 3'd0);
      tick();
      idle();
      bus.in_flush = 1'b1;
      bus.in_stall = 1'b1;
      tick();
      bus.in_flush = 1'b0;
      bus.in_stall = 1'b0;
      for (int c = 0; c < LAT + 1; c++) begin
         checks++;
         if (bus.out_valid !== 1'b0 || bus.out_busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_over_stall cycle %0d: got v=%b busy=%b expected 0 0", c,
                     bus.out_valid, bus.out_busy);
         end
         tick();
      end
   endtask

   task automatic test_hazard();
      bus.in_dec_rs1 = 5'd9;
      bus.in_dec_rs2 = 5'd5;
      set_op(F3_MUL, 32'd2, 32'd2, 5'd5, 32'h700, 4'd2, 3'd0);
      checks++;
      if (bus.out_raw_hazard !== 1'b0) begin
         errors++;
         $display("FAIL hazard_idex: got %b expected 0", bus.out_raw_hazard);
      end
      tick();
      idle();
      for (int c = 1; c <= LAT + 1; c++) begin
         checks++;
         if (bus.out_raw_hazard !== (c <= LAT)) begin
            errors++;
            $display("FAIL hazard cycle %0d: got %b expected %b", c, bus.out_raw_hazard, c <= LAT);
         end
         tick();
      end
      bus.in_dec_rs1 = 5'd0;
      bus.in_dec_rs2 = 5'd3;
      set_op(F3_MUL, 32'd2, 32'd2, 5'd0, 32'h704, 4'd3, 3'd0);
      tick();
      idle();
      for (int c = 1; c <= LAT; c++) begin
         checks++;
         if (bus.out_raw_hazard !== 1'b0) begin
            errors++;
            $display("FAIL hazard_rd0 cycle %0d: got %b expected 0", c, bus.out_raw_hazard);
         end
         tick();
      end
   endtask

   task automatic test_exception();
      set_op(3'b100, 32'd7, 32'd6, 5'd3, 32'h800, 4'd5, 3'd0);
      tick();
      set_op(F3_MUL, 32'd7, 32'd6, 5'd3, 32'h804, 4'd6, 3'b001);
      tick();
      set_op(3'b101, 32'd7, 32'd6, 5'd3, 32'h808, 4'd7, 3'b001);
      tick();
      idle();
      repeat (LAT - 3) tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_exception_vector !== 3'b010 ||
          bus.out_result !== 32'd0 || bus.out_write_enable !== 1'b0) begin
         errors++;
         $display("FAIL exc_illegal: got v=%b exc=%b res=%h we=%b expected 1 010 0 0",
                  bus.out_valid, bus.out_exception_vector, bus.out_result, bus.out_write_enable);
      end
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_exception_vector !== 3'b001 ||
          bus.out_result !== 32'd0 || bus.out_write_enable !== 1'b0) begin
         errors++;
         $display("FAIL exc_passthru: got v=%b exc=%b res=%h we=%b expected 1 001 0 0",
                  bus.out_valid, bus.out_exception_vector, bus.out_result, bus.out_write_enable);
      end
      tick();
      checks++;
      if (bus.out_exception_vector !== 3'b001 || bus.out_write_enable !== 1'b0) begin
         errors++;
         $display("FAIL exc_passthru_div: got exc=%b we=%b expected 001 0",
                  bus.out_exception_vector, bus.out_write_enable);
      end
   endtask

   task automatic test_reset_mid();
      set_op(F3_MUL, 32'd11, 32'd13, 5'd6, 32'h900, 4'd8, 3'd0);
      tick();
      set_op(F3_MUL, 32'd17, 32'd19, 5'd7, 32'h904, 4'd9, 3'd0);
      tick();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if ({bus.out_valid, bus.out_write_enable, bus.out_busy, bus.out_result, bus.out_rd,
           bus.out_PC, bus.out_complete_idx, bus.out_exception_vector} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got v=%b we=%b busy=%b res=%h rd=%0d pc=%h idx=%0d exc=%0d expected all 0",
                  bus.out_valid, bus.out_write_enable, bus.out_busy, bus.out_result, bus.out_rd,
                  bus.out_PC, bus.out_complete_idx, bus.out_exception_vector);
      end
      for (int c = 0; c < LAT + 2; c++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_emit cycle %0d: got v=%b expected 0", c, bus.out_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [31:0] b;
      logic        ev;
      logic        ewe;
      for (int n = 0; n < 400; n++) begin
         a = $urandom;
         b = $urandom;
         if ($urandom_range(0, 5) == 0) a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h8000_0000;
         if ($urandom_range(0, 5) == 0) b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
         if ($urandom_range(0, 3) == 0) idle();
         else set_op(($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
                     a, b, 5'($urandom_range(0, 7)), $urandom, 4'($urandom),
                     ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : 3'd0);
         bus.in_stall   = ($urandom_range(0, 6) == 0);
         bus.in_flush   = ($urandom_range(0, 24) == 0);
         bus.in_dec_rs1 = 5'($urandom_range(0, 7));
         bus.in_dec_rs2 = 5'($urandom_range(0, 7));
         tick();
         ev  = model_valid();
         ewe = ev && mq[0].rd != 5'd0 && mq[0].exc == 3'd0;
         checks++;
         if (bus.out_valid !== ev || bus.out_write_enable !== ewe ||
             bus.out_busy !== (mq.size() > 0) || bus.out_raw_hazard !== model_hazard()) begin
            errors++;
            $display("FAIL rand_ctrl %0d: got v=%b we=%b busy=%b hz=%b expected %b %b %b %b", n,
                     bus.out_valid, bus.out_write_enable, bus.out_busy, bus.out_raw_hazard,
                     ev, ewe, mq.size() > 0, model_hazard());
         end
         if (ev) begin
            checks++;
            if (bus.out_result !== mq[0].res || bus.out_rd !== mq[0].rd || bus.out_PC !== mq[0].pc ||
                bus.out_complete_idx !== mq[0].idx || bus.out_exception_vector !== mq[0].exc) begin
               errors++;
               $display("FAIL rand_data %0d: got res=%h rd=%0d pc=%h idx=%0d exc=%0d expected %h %0d %h %0d %0d",
                        n, bus.out_result, bus.out_rd, bus.out_PC, bus.out_complete_idx,
                        bus.out_exception_vector, mq[0].res, mq[0].rd, mq[0].pc, mq[0].idx, mq[0].exc);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      drain();
      test_signedness();
      drain();
      test_stall();
      drain();
      test_flush();
      drain();
      test_hazard();
      drain();
      test_exception();
      drain();
      test_reset_mid();
      drain();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
